async_fifo_rd_drain: RTL and testbench

//  Read-clock-domain consumer of the async FIFO. Drives the FIFO read port, absorbs its
//  1-cycle registered read latency in a small credit-managed buffer, and presents a

---
 rtl/async_fifo_rd_drain_pkg.sv | 12 +
 rtl/async_fifo_rd_drain_skid_buf.sv | 53 +++++
 rtl/async_fifo_rd_drain.sv | 111 +++++++++++
 tb/tb_async_fifo_rd_drain.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_rd_drain_pkg.sv
// Shared types and constants for the async FIFO read-side drain logic.
package async_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } rd_drain_state_e;

   localparam int BUF_DEPTH_MIN = 2;

endpackage

// File: rtl/async_fifo_rd_drain_skid_buf.sv
// Small register FIFO that lands FIFO read data and holds it stable under backpressure.
// Head entry is presented combinationally; push and pop on the same edge keep occupancy.
module rd_skid_buf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         read_clk,
   input  logic                         async_rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         not_empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Storage is reset so the stream data port reads zero straight out of reset.
   always_ff @(posedge read_clk or negedge async_rst) begin
      if (!async_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         if (push && !pop)      occupancy <= occupancy + OW'(1);
         else if (!push && pop) occupancy <= occupancy - OW'(1);
      end
   end

   assign head_data = mem[rd_ptr];
   assign not_empty = (occupancy != '0);

   a_no_overflow : assert property (@(posedge read_clk) disable iff (!async_rst)
      !(push && !pop && (occupancy == OW'(DEPTH))));
   a_no_underflow : assert property (@(posedge read_clk) disable iff (!async_rst)
      !(pop && (occupancy == '0)));

endmodule

// File: rtl/async_fifo_rd_drain.sv
// Read-domain drain of the async FIFO: credit-limited reads into a skid buffer, framed into
// BURST_LEN-beat bursts on a valid/ready stream. ASYNC_FIFO_RD_STATS_EN adds a stall counter.
module async_fifo_rd_drain
   import async_fifo_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int BURST_LEN = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic             read_clk,
   input  logic             async_rst,
   input  logic             enable,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             busy
`ifdef ASYNC_FIFO_RD_STATS_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int OW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

   if (BUF_DEPTH < BUF_DEPTH_MIN) begin : g_depth_chk
      $error("BUF_DEPTH below BUF_DEPTH_MIN");
   end

   rd_drain_state_e state, state_nxt;
   logic            inflight;
   logic [CW-1:0]   beat_cnt;
   logic [CW-1:0]   iss_cnt;
   logic [OW-1:0]   occ;
   logic [OW:0]     pend;
   logic            pop;
   logic            credit;
   logic            burst_open;

   rd_skid_buf #(
      .WIDTH (WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .read_clk  (read_clk),
      .async_rst (async_rst),
      .push      (inflight),
      .push_data (fifo_data),
      .pop       (pop),
      .head_data (m_data),
      .occupancy (occ),
      .not_empty (m_valid)
   );

   // A beat leaving this cycle frees its slot in time for a read issued now.
   assign pop        = m_valid & m_ready;
   assign pend       = {1'b0, occ} + (OW+1)'(inflight) - (OW+1)'(pop);
   assign credit     = (pend < (OW+1)'(BUF_DEPTH));
   assign burst_open = (iss_cnt != '0);
   assign m_last     = m_valid & (beat_cnt == LAST_BEAT);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      fifo_rd_en = 1'b0;
      unique case (state)
         IDLE: begin
            if (enable && !fifo_empty) state_nxt = RUN;
         end
         RUN: begin
            fifo_rd_en = !fifo_empty && credit;
            if (!enable) state_nxt = STOP;
         end
         STOP: begin
            // Only finish the burst already started on the read side.
            fifo_rd_en = !fifo_empty && credit && burst_open;
            if (enable) state_nxt = RUN;
            else if (occ == '0 && !inflight && beat_cnt == '0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge read_clk or negedge async_rst) begin
      if (!async_rst) begin
         state    <= IDLE;
         inflight <= 1'b0;
         beat_cnt <= '0;
         iss_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_rd_en;
         if (pop)        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
         if (fifo_rd_en) iss_cnt  <= (iss_cnt == LAST_BEAT) ? '0 : iss_cnt + CW'(1);
      end
   end

`ifdef ASYNC_FIFO_RD_STATS_EN
   always_ff @(posedge read_clk or negedge async_rst) begin
      if (!async_rst) begin
         stall_cnt <= '0;
      end else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Bench for async_fifo_rd_drain: queue-based source FIFO and stream scoreboard.
// Stimulus driven at falling edge, sampled 1 time unit later.
// Stream backpressure modelled by ready_mode (always, toggle, random, never).
module tb_async_fifo_rd_drain;
    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 8;
    localparam int BUF_DEPTH = 2;

    logic             read_clk = 1'b0;
    logic             async_rst;
    logic             enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_rd_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [15:0]      stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH:0]   got_q[$];
    int               reads, accepts, viol, ready_mode, stall_model;
    bit               rd_pend, prev_stall, hold_empty, tog, en_drv;
    bit               s_rd, s_vld, s_busy;
    logic [WIDTH-1:0] nxt_data, prev_data;
    logic             prev_last;

    always #5 read_clk = ~read_clk;

    async_fifo_rd_drain #(
        .WIDTH     (WIDTH),
        .BURST_LEN (BURST_LEN),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .read_clk   (read_clk),
        .async_rst  (async_rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
`ifdef ASYNC_FIFO_RD_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic step();
        bit rdy;
        @(negedge read_clk);
        if (rd_pend) fifo_data = nxt_data;
        fifo_empty = hold_empty || (fifo_q.size() == 0);
        enable     = en_drv;
        case (ready_mode)
            0: rdy = 1'b1;
            1: begin tog = ~tog; rdy = tog; end
            2: rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b0;
        endcase
        m_ready = rdy;
        #1;
        s_rd   = fifo_rd_en;
        s_vld  = m_valid;
        s_busy = busy;
        if (s_rd && fifo_empty) viol++;
        if (s_rd && (reads - accepts - int'(s_vld && rdy)) >= BUF_DEPTH) viol++;
        if (prev_stall && (!s_vld || m_data !== prev_data || m_last !== prev_last)) viol++;
        if (s_vld && rdy) begin
            got_q.push_back({m_last, m_data});
            accepts++;
        end
        if (s_vld && !rdy && stall_model < 65535) stall_model++;
        rd_pend = s_rd;
        if (s_rd) begin
            nxt_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
            reads++;
        end
        prev_stall = s_vld && !rdy;
        prev_data  = m_data;
        prev_last  = m_last;
    endtask

    task automatic reset_dut();
        async_rst  = 1'b0;
        enable     = 1'b0;
        en_drv     = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        hold_empty = 1'b0;
        ready_mode = 0;
        tog        = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        got_q.delete();
        reads = 0; accepts = 0; viol = 0; stall_model = 0;
        rd_pend = 1'b0; prev_stall = 1'b0;
        repeat (2) @(negedge read_clk);
        async_rst = 1'b1;
    endtask

    task automatic load_random(input int n);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic test_reset();
        async_rst  = 1'b0;
        enable     = 1'b1;
        en_drv     = 1'b1;
        fifo_empty = 1'b0;
        m_ready    = 1'b1;
        fifo_data  = $urandom;
        repeat (3) @(negedge read_clk);
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%b vld=%b last=%b busy=%b data=%h, want all 0",
                     fifo_rd_en, m_valid, m_last, busy, m_data);
        end
        async_rst = 1'b1;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_read: got rd_en=%b busy=%b, want 0 0", fifo_rd_en, busy);
        end
        @(posedge read_clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_to_run: got busy=%b, want 1", busy);
        end
    endtask

    task automatic test_burst();
        int first_rd = -1, last_rd = -1, first_vld = -1, last_vld = -1;
        logic l;
        reset_dut();
        for (int i = 1; i <= 8; i++) begin
            fifo_q.push_back(WIDTH'(i));
            exp_q.push_back(WIDTH'(i));
        end
        en_drv = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (s_rd)  begin if (first_rd < 0) first_rd = c; last_rd = c; end
            if (s_vld) begin if (first_vld < 0) first_vld = c; last_vld = c; end
        end
        checks++;
        if (reads != 8 || last_rd - first_rd != 7) begin
            errors++;
            $display("FAIL burst_reads: got %0d reads over %0d cycles, want 8 over 8", reads, last_rd - first_rd + 1);
        end
        checks++;
        if (first_vld - first_rd != 2) begin
            errors++;
            $display("FAIL burst_latency: got %0d cycles rd_en->valid, want 2", first_vld - first_rd);
        end
        checks++;
        if (accepts != 8 || last_vld - first_vld != 7) begin
            errors++;
            $display("FAIL burst_b2b: got %0d beats over %0d cycles, want 8 over 8", accepts, last_vld - first_vld + 1);
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            checks++;
            if (got_q[i] !== {l, exp_q[i]}) begin
                errors++;
                $display("FAIL burst_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL burst_protocol: got %0d violations, want 0", viol);
        end
    endtask

    task automatic test_ready_toggle();
        logic l;
        reset_dut();
        load_random(16);
        en_drv     = 1'b1;
        ready_mode = 1;
        for (int c = 0; c < 200 && accepts < 16; c++) step();
        repeat (5) step();
        checks++;
        if (got_q.size() != 16) begin
            errors++;
            $display("FAIL toggle_count: got %0d beats, want 16", got_q.size());
        end
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            checks++;
            if (got_q[i] !== {l, exp_q[i]}) begin
                errors++;
                $display("FAIL toggle_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL toggle_protocol: got %0d violations, want 0", viol);
        end
    endtask

    task automatic test_enable_drop();
        bit busy_at8;
        logic l;
        reset_dut();
        load_random(20);
        en_drv = 1'b1;
        for (int c = 0; c < 60 && accepts < 3; c++) step();
        en_drv = 1'b0;
        for (int c = 0; c < 60 && accepts < 8; c++) step();
        busy_at8 = s_busy;
        for (int c = 0; c < 10 && s_busy; c++) step();
        checks++;
        if (s_busy) begin
            errors++;
            $display("FAIL drop_busy_fall: got busy=1 after burst closed, want 0");
        end
        repeat (10) step();
        checks++;
        if (!busy_at8) begin
            errors++;
            $display("FAIL drop_busy_held: got busy=0 while beat 8 accepted, want 1");
        end
        checks++;
        if (reads != 8 || fifo_q.size() != 12) begin
            errors++;
            $display("FAIL drop_reads: got %0d reads, %0d left in FIFO, want 8 and 12", reads, fifo_q.size());
        end
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL drop_count: got %0d beats, want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            checks++;
            if (got_q[i] !== {l, exp_q[i]}) begin
                errors++;
                $display("FAIL drop_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
            end
        end
    endtask

    task automatic test_empty_gap();
        int gap_vld = 0;
        logic l;
        reset_dut();
        load_random(5);
        en_drv = 1'b1;
        for (int c = 0; c < 40 && accepts < 5; c++) step();
        for (int c = 0; c < 3; c++) begin
            step();
            if (s_vld || s_rd) gap_vld++;
        end
        checks++;
        if (gap_vld != 0) begin
            errors++;
            $display("FAIL gap_idle: got %0d active cycles in gap, want 0", gap_vld);
        end
        load_random(3);
        for (int c = 0; c < 40 && accepts < 8; c++) step();
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL gap_count: got %0d beats, want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            checks++;
            if (got_q[i] !== {l, exp_q[i]}) begin
                errors++;
                $display("FAIL gap_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
            end
        end
    endtask

    task automatic test_async_reset();
        logic l;
        reset_dut();
        load_random(24);
        en_drv = 1'b1;
        for (int c = 0; c < 60 && !(accepts >= 3 && rd_pend); c++) step();
        checks++;
        if (!rd_pend) begin
            errors++;
            $display("FAIL arst_setup: got no read in flight, want one");
        end
        #2 async_rst = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_last, busy, m_data} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: got rd_en=%b vld=%b last=%b busy=%b data=%h, want all 0",
                     fifo_rd_en, m_valid, m_last, busy, m_data);
        end
        // The word already read from the FIFO is lost; the stream resumes with what remains.
        exp_q = fifo_q;
        got_q.delete();
        reads = 0; accepts = 0; rd_pend = 1'b0; prev_stall = 1'b0;
        @(negedge read_clk);
        async_rst = 1'b1;
        for (int c = 0; c < 60 && accepts < 8; c++) step();
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL arst_count: got %0d beats, want 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            checks++;
            if (got_q[i] !== {l, exp_q[i]}) begin
                errors++;
                $display("FAIL arst_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
            end
        end
    endtask

    task automatic test_random();
        logic l;
        int   bad = 0;
        reset_dut();
        load_random(60);
        ready_mode = 2;
        for (int c = 0; c < 400; c++) begin
            hold_empty = ($urandom_range(0, 4) == 0);
            en_drv     = ($urandom_range(0, 9) != 0);
            step();
        end
        hold_empty = 1'b0;
        en_drv     = 1'b1;
        ready_mode = 0;
        for (int c = 0; c < 200 && accepts < 60; c++) step();
        checks++;
        if (got_q.size() != 60) begin
            errors++;
            $display("FAIL random_count: got %0d beats, want 60", got_q.size());
        end
        for (int i = 0; i < 60 && i < got_q.size(); i++) begin
            l = ((i % BURST_LEN) == BURST_LEN - 1);
            if (got_q[i] !== {l, exp_q[i]}) begin
                if (bad == 0) $display("FAIL random_beat%0d: got %h, want %h", i, got_q[i], {l, exp_q[i]});
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_stream: got %0d wrong beats, want 0", bad);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL random_protocol: got %0d violations, want 0", viol);
        end
    endtask

`ifdef ASYNC_FIFO_RD_STATS_EN
    task automatic test_stall_stats();
        reset_dut();
        load_random(4);
        en_drv     = 1'b1;
        ready_mode = 3;
        for (int c = 0; c < 50 && stall_model < 10; c++) step();
        @(posedge read_clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd10) begin
            errors++;
            $display("FAIL stall_ten: got %0d, want 10", stall_cnt);
        end
        repeat (70000) @(posedge read_clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_saturate: got %h, want ffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_burst();
        test_ready_toggle();
        test_enable_drop();
        test_empty_gap();
        test_async_reset();
        test_random();
`ifdef ASYNC_FIFO_RD_STATS_EN
        test_stall_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
